// File: rtl/xor_share_pkg.sv
// Shared types and helpers for the xor_share_arb round-robin sequencer.
package xor_share_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF    = 10;

  // Helpers work on a fixed maximum width so that any instance up to
  // MAX_REQ requesters can reuse them through width casts.
  localparam int MAX_REQ   = 32;
  localparam int MAX_ID_W  = 5;

  // One-hot grant for the first valid requester at ptr+1, ptr+2, ...
  // The scan wraps modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input int ptr,
                                                 input int n);
    logic [MAX_REQ-1:0] g;
    logic               found;
    int                 idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n && !found) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[MAX_ID_W-1:0]]) begin
          g[idx[MAX_ID_W-1:0]] = 1'b1;
          found                = 1'b1;
        end
      end
    end
    return g;
  endfunction

  function automatic logic [MAX_ID_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) r = r | MAX_ID_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Owns the last-grant pointer, which moves to the
// granted index only when adv signals that the grant was accepted.
module rr_arbiter
  import xor_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_valid,
  input  logic             adv,
  output logic [N_REQ-1:0] grant
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] ptr;

  assign grant = N_REQ'(rr_pick(MAX_REQ'(req_valid), 32'(ptr), N_REQ));

  // Reset to the last index so requester 0 has top priority after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= ID_W'(N_REQ - 1);
    end else if (adv && |grant) begin
      ptr <= ID_W'(onehot2idx(MAX_REQ'(grant)));
    end
  end

endmodule

// File: rtl/xorf.sv
// Conditional inverter: c = a when b=0, ~a when b=1.
module xorf #(
  parameter int DW = 10
) (
  input  logic [DW-1:0] a,
  input  logic          b,
  output logic [DW-1:0] c
);

  assign c = a ^ {DW{b}};

endmodule

// File: rtl/xor_share_arb.sv
// Shares one xorf datapath among N_REQ requesters through a round-robin grant,
// with a single registered valid/ready output stage and a saturating transfer count.
module xor_share_arb
  import xor_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*DW-1:0]      req_data,
  input  logic [N_REQ-1:0]         req_inv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(N_REQ)-1:0] out_id,
  output logic [CNT_W-1:0]         txn_count
);

  localparam int ID_W = $clog2(N_REQ);

  logic             load_en;
  logic [N_REQ-1:0] grant;
  logic [DW-1:0]    sel_data;
  logic             sel_inv;
  logic [DW-1:0]    xor_data;
  logic             take;

  assign load_en = !out_valid || out_ready;

  // Gating with rst_n keeps req_ready low for the whole time reset is held.
  assign req_ready = grant & {N_REQ{load_en && rst_n}};
  assign take      = |req_ready;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .adv       (take),
    .grant     (grant)
  );

  always_comb begin
    sel_data = '0;
    sel_inv  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | req_data[i*DW +: DW];
        sel_inv  = sel_inv | req_inv[i];
      end
    end
  end

  xorf #(
    .DW (DW)
  ) u_xorf (
    .a (sel_data),
    .b (sel_inv),
    .c (xor_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= xor_data;
      out_id    <= ID_W'(onehot2idx(MAX_REQ'(grant)));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (out_valid && out_ready && (txn_count != {CNT_W{1'b1}})) begin
      txn_count <= txn_count + 1'b1;
    end
  end

endmodule
